control_cmd_router: RTL

- Byte-stream command dispatcher sitting directly upstream of control_cmd_watchdog and the other control-command sub-blocks.
- Consumes the UART receive byte stream and treats the first byte of each command as an opcode.
- Forwards each following byte to the selected sub-block as a one-cycle enable plus data.
- Returns to opcode-hunting when that sub-block pulses done.

---
 rtl/control_cmd_router.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/control_cmd_router.sv
// Opcode-driven byte router from the UART RX stream to the control sub-blocks.
// Optional mid-command idle timeout is built when CMD_TIMEOUT_EN is defined.
module control_cmd_router #(
    parameter logic [7:0]  WATCHDOG_OPCODE   = 8'h57,
    parameter logic [7:0]  BRIGHTNESS_OPCODE = 8'h54,
    parameter int unsigned TIMEOUT_TICKS     = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       wd_done,
    input  logic       br_done,
    output logic [7:0] cmd_data,
    output logic       wd_enable,
    output logic       br_enable,
    output logic       busy,
    output logic       unknown_opcode,
    output logic [7:0] err_count,
    output logic       cmd_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE_WD,
        ROUTE_BR
    } state_t;

    if (TIMEOUT_TICKS < 2) begin : g_bad_ticks
        $error("control_cmd_router: TIMEOUT_TICKS must be >= 2");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cmd_data;
    logic [7:0] w_cmd_data_nxt;
    logic       r_wd_en;
    logic       w_wd_en_nxt;
    logic       r_br_en;
    logic       w_br_en_nxt;
    logic       r_busy;
    logic       r_unknown;
    logic       w_unknown_nxt;
    logic [7:0] r_err;
    logic       w_err_inc;
    logic [7:0] w_err_nxt;
    logic       w_in_route;
    logic       w_done_sel;

    assign w_in_route = (r_state != IDLE);
    assign w_done_sel = ((r_state == ROUTE_WD) && wd_done)
                     || ((r_state == ROUTE_BR) && br_done);

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_TICKS);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    logic          w_load;
    logic          w_expire;

    // Any accepted byte that leaves us routing is either an entry or a forward.
    assign w_load   = rx_valid && (w_state_nxt != IDLE);
    assign w_expire = w_in_route && !w_done_sel && !rx_valid
                   && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_load) begin
                r_cnt <= LOAD_VAL;
            end else if (w_in_route && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign cmd_timeout = r_timeout;
`else
    assign cmd_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_data_nxt = r_cmd_data;
        w_wd_en_nxt    = 1'b0;
        w_br_en_nxt    = 1'b0;
        w_unknown_nxt  = 1'b0;
        w_err_inc      = 1'b0;
        // A byte arriving with done is judged as the next opcode.
        if (!w_in_route || w_done_sel) begin
            w_state_nxt = IDLE;
            if (rx_valid) begin
                if (rx_data == WATCHDOG_OPCODE) begin
                    w_state_nxt = ROUTE_WD;
                end else if (rx_data == BRIGHTNESS_OPCODE) begin
                    w_state_nxt = ROUTE_BR;
                end else begin
                    w_unknown_nxt = 1'b1;
                    w_err_inc     = 1'b1;
                end
            end
        end else if (rx_valid) begin
            w_cmd_data_nxt = rx_data;
            w_wd_en_nxt    = (r_state == ROUTE_WD);
            w_br_en_nxt    = (r_state == ROUTE_BR);
`ifdef CMD_TIMEOUT_EN
        end else if (w_expire) begin
            w_state_nxt = IDLE;
            w_err_inc   = 1'b1;
`endif
        end
    end

    assign w_err_nxt = (w_err_inc && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cmd_data <= 8'h00;
            r_wd_en    <= 1'b0;
            r_br_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_unknown  <= 1'b0;
            r_err      <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_data <= w_cmd_data_nxt;
            r_wd_en    <= w_wd_en_nxt;
            r_br_en    <= w_br_en_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_unknown  <= w_unknown_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign cmd_data       = r_cmd_data;
    assign wd_enable      = r_wd_en;
    assign br_enable      = r_br_en;
    assign busy           = r_busy;
    assign unknown_opcode = r_unknown;
    assign err_count      = r_err;

endmodule
